fetch_front_end: RTL and testbench

- Instruction-fetch front end of the 5-stage pipeline: PC and nPC registers, a +4 incrementer, and the IF/ID pipeline register.
- Drives the byte address to the external instruction memory and captures the returned instruction word for the ID stage.
- Uses delayed-branch sequencing: each cycle PC takes nPC, and nPC takes either nPC+4 or a branch target.

---
 rtl/fetch_pkg.sv | 8 +
 rtl/pc_incrementer.sv | 10 +
 rtl/fetch_front_end.sv | 65 ++++++
 tb/tb_fetch_front_end.sv | 148 ++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared constants for the instruction-fetch front end.
package fetch_pkg;
  localparam int          ADDR_W    = 32;
  localparam int          INSTR_W   = 32;
  localparam logic [31:0] STEP      = 32'd4;
  localparam logic [31:0] RESET_PC  = 32'h0;
  localparam logic [31:0] NOP_INSTR = 32'h0;
endpackage

// File: rtl/pc_incrementer.sv
// Combinational address incrementer: sum = addr + STEP, modulo 2^W.
module pc_incrementer #(
  parameter int           W    = 32,
  parameter logic [W-1:0] STEP = W'(4)
) (
  input  logic [W-1:0] addr,
  output logic [W-1:0] sum
);
  assign sum = addr + STEP;
endmodule

// File: rtl/fetch_front_end.sv
// PC/nPC delayed-branch sequencer plus IF/ID register; instruction at pc appears on ifid_instr one edge later.
// le=0 stalls PC, nPC and IF/ID; flush zeroes IF/ID regardless of le.
module fetch_front_end
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = fetch_pkg::ADDR_W,
  parameter int                INSTR_W  = fetch_pkg::INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(fetch_pkg::RESET_PC),
  parameter logic [ADDR_W-1:0] STEP     = ADDR_W'(fetch_pkg::STEP)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               le,
  input  logic               taken,
  input  logic [ADDR_W-1:0]  target,
  input  logic               flush,
  input  logic [INSTR_W-1:0] imem_data,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [ADDR_W-1:0]  pc_out,
  output logic [ADDR_W-1:0]  npc_out,
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc
);

  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] npc;
  logic [ADDR_W-1:0] npc_inc;
  logic [ADDR_W-1:0] npc_next;

  pc_incrementer #(
    .W    (ADDR_W),
    .STEP (STEP)
  ) u_inc (
    .addr (npc),
    .sum  (npc_inc)
  );

  // Delayed branch: pc always takes npc, so the delay slot is fetched before the target.
  assign npc_next = taken ? target : npc_inc;

  always_ff @(posedge clk) begin
    if (reset) begin
      pc <= RESET_PC;
      npc <= RESET_PC + STEP;
    end else if (le) begin
      pc <= npc;
      npc <= npc_next;
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      ifid_instr <= INSTR_W'(NOP_INSTR);
      ifid_pc <= '0;
    end else if (le) begin
      ifid_instr <= imem_data;
      ifid_pc <= pc;
    end
  end

  assign imem_addr = pc;
  assign pc_out = pc;
  assign npc_out = npc;

endmodule

// File: tb/tb_fetch_front_end.sv
// Table-driven bench for fetch_front_end with an expected-value scoreboard queue.
module tb_fetch_front_end;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        le = 1'b0;
  logic        taken = 1'b0;
  logic [31:0] target = '0;
  logic        flush = 1'b0;
  logic [31:0] imem_data;
  logic [31:0] imem_addr;
  logic [31:0] pc_out;
  logic [31:0] npc_out;
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        rst;
    logic        le;
    logic        taken;
    logic        flush;
    logic [31:0] target;
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] instr;
    logic [31:0] ifpc;
  } vec_t;

  vec_t vecs[$];
  vec_t sb[$];

  fetch_front_end dut (
    .clk        (clk),
    .reset      (reset),
    .le         (le),
    .taken      (taken),
    .target     (target),
    .flush      (flush),
    .imem_data  (imem_data),
    .imem_addr  (imem_addr),
    .pc_out     (pc_out),
    .npc_out    (npc_out),
    .ifid_instr (ifid_instr),
    .ifid_pc    (ifid_pc)
  );

  always #5 clk = ~clk;

  // Instruction memory: word at address A is A, except one recognisable word at 0x18.
  always_comb begin
    imem_data = imem_addr;
    if (imem_addr == 32'h18) imem_data = 32'h2400_0005;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic vec_t mk(logic r, logic l, logic t, logic f, logic [31:0] tg,
                              logic [31:0] p, logic [31:0] n, logic [31:0] i, logic [31:0] ip);
    vec_t v;
    v.rst = r; v.le = l; v.taken = t; v.flush = f; v.target = tg;
    v.pc = p; v.npc = n; v.instr = i; v.ifpc = ip;
    return v;
  endfunction

  task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drive one edge's inputs, queue its expected result, then compare after the edge.
  task automatic step(vec_t v, string tag);
    vec_t e;
    @(negedge clk);
    reset = v.rst; le = v.le; taken = v.taken; flush = v.flush; target = v.target;
    sb.push_back(v);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s scoreboard: got empty queue expected entry", tag);
    end else begin
      e = sb.pop_front();
      check({tag, " pc"}, pc_out, e.pc);
      check({tag, " npc"}, npc_out, e.npc);
      check({tag, " ifid_instr"}, ifid_instr, e.instr);
      check({tag, " ifid_pc"}, ifid_pc, e.ifpc);
      check({tag, " imem_addr"}, imem_addr, e.pc);
    end
  endtask

  initial begin
    //              rst le tk fl target         pc            npc           instr         ifid_pc
    vecs.push_back(mk(1, 1, 0, 0, 32'h0,        32'h0,        32'h4,        32'h0,        32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        32'h4,        32'h8,        32'h0,        32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        32'h8,        32'hC,        32'h4,        32'h4));
    vecs.push_back(mk(0, 1, 1, 0, 32'h40,       32'hC,        32'h40,       32'h8,        32'h8));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        32'h40,       32'h44,       32'hC,        32'hC));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        32'h44,       32'h48,       32'h40,       32'h40));
    vecs.push_back(mk(0, 1, 1, 0, 32'h10,       32'h48,       32'h10,       32'h44,       32'h44));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        32'h10,       32'h14,       32'h48,       32'h48));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h10,       32'h14,       32'h48,       32'h48));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h10,       32'h14,       32'h48,       32'h48));
    vecs.push_back(mk(0, 0, 0, 0, 32'h0,        32'h10,       32'h14,       32'h48,       32'h48));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        32'h14,       32'h18,       32'h10,       32'h10));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        32'h18,       32'h1C,       32'h14,       32'h14));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        32'h1C,       32'h20,       32'h2400_0005, 32'h18));
    vecs.push_back(mk(0, 1, 0, 1, 32'h0,        32'h20,       32'h24,       32'h0,        32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        32'h24,       32'h28,       32'h20,       32'h20));
    vecs.push_back(mk(0, 0, 0, 1, 32'h0,        32'h24,       32'h28,       32'h0,        32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        32'h28,       32'h2C,       32'h24,       32'h24));
    vecs.push_back(mk(0, 0, 1, 0, 32'h80,       32'h28,       32'h2C,       32'h24,       32'h24));
    vecs.push_back(mk(0, 1, 1, 0, 32'h80,       32'h2C,       32'h80,       32'h28,       32'h28));
    vecs.push_back(mk(0, 1, 1, 0, 32'hFFFF_FFFC, 32'h80,      32'hFFFF_FFFC, 32'h2C,      32'h2C));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        32'hFFFF_FFFC, 32'h0,       32'h80,       32'h80));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        32'h0,        32'h4,        32'hFFFF_FFFC, 32'hFFFF_FFFC));
    vecs.push_back(mk(1, 1, 1, 1, 32'h55,       32'h0,        32'h4,        32'h0,        32'h0));
    vecs.push_back(mk(0, 1, 0, 0, 32'h0,        32'h4,        32'h8,        32'h0,        32'h0));

    for (int i = 0; i < vecs.size(); i++) step(vecs[i], $sformatf("vec%0d", i));

    // Hand-written: reset wins over a stall, then a flush during reset-release.
    step(mk(0, 1, 0, 0, 32'h0, 32'h8, 32'hC, 32'h4, 32'h4), "seq_run");
    step(mk(1, 0, 1, 0, 32'h99, 32'h0, 32'h4, 32'h0, 32'h0), "seq_rst_stall");
    step(mk(0, 1, 0, 1, 32'h0, 32'h4, 32'h8, 32'h0, 32'h0), "seq_flush_first");
    step(mk(0, 1, 1, 0, 32'h100, 32'h8, 32'h100, 32'h4, 32'h4), "seq_branch");
    step(mk(0, 1, 0, 0, 32'h0, 32'h100, 32'h104, 32'h8, 32'h8), "seq_target");

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
